// File: rtl/sr_shift_ctrl.sv
// sr_shift_ctrl -- sequencing controller for a serial-in, shift-right shift
// register (the serial bit enters the MSB, so the first bit received ends up
// in bit 0). One request frames one WIDTH-bit word. The controller clears the
// register and shifts it WIDTH times. It then captures the parallel state into
// an output holding register, which is offered on a valid/ready handshake.
//
// Optional feature macro: SR_PARITY_EN
//   defined   : a one-cycle PARITY state follows SHIFT. ser_in is sampled there
//               as an even-parity bit. par_err is registered with dout at
//               capture.
//   undefined : there is no PARITY state, par_err is tied to 0 and ser_in is
//               ignored.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      request one word (sampled at the clock edge)
//   abort      cancel the word in progress
//   ser_in     serial line, used only as the parity bit
//   sr_state   parallel state of the shift register
//   sr_clear   one-cycle clear pulse to the shift register
//   sr_shift   shift enable to the shift register
//   busy       controller is not idle
//   dout       captured word, stable while dout_valid=1
//   dout_valid captured word available
//   dout_ready consumer accepts dout
//   par_err    parity error of the word on dout
//   overrun    sticky: start seen while a word was being framed
module sr_shift_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic             ser_in,
   input  logic [WIDTH-1:0] sr_state,
   output logic             sr_clear,
   output logic             sr_shift,
   output logic             busy,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             par_err,
   output logic             overrun
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CLEAR   = 3'd1,
      SHIFT   = 3'd2,
      PARITY  = 3'd3,
      CAPTURE = 3'd4,
      HOLD    = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] dout_q;
   logic             dout_valid_q;
   logic             par_err_q;
   logic             overrun_q;

   // The output slot can take a new word if it is empty or is being drained
   // at this same edge.
   logic slot_free;
   assign slot_free = !dout_valid_q || dout_ready;

   // This is the parity result that would be registered if a capture happened
   // at this edge.
   logic par_calc;

`ifdef SR_PARITY_EN
   logic par_bit_q;
   assign par_calc = (^sr_state) ^ par_bit_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                 par_bit_q <= 1'b0;
      else if (state_q == PARITY) par_bit_q <= ser_in;
   end
`else
   logic unused_ser_in;
   assign unused_ser_in = ser_in;
   assign par_calc      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         // Plain accept. A capture further down overrides this and keeps
         // valid high.
         if (dout_valid_q && dout_ready) dout_valid_q <= 1'b0;

         case (state_q)
            IDLE: begin
               if (start) state_q <= CLEAR;
            end

            CLEAR: begin
               cnt_q <= '0;
               if (start) overrun_q <= 1'b1;
               state_q <= abort ? IDLE : SHIFT;
            end

            SHIFT: begin
               if (start) overrun_q <= 1'b1;
               if (abort) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == LAST_CNT) begin
`ifdef SR_PARITY_EN
                     state_q <= PARITY;
`else
                     state_q <= CAPTURE;
`endif
                  end
               end
            end

            PARITY: begin
               if (start) overrun_q <= 1'b1;
               if (abort) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  state_q <= CAPTURE;
               end
            end

            CAPTURE, HOLD: begin
               if (abort) begin
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else if (slot_free) begin
                  dout_q       <= sr_state;
                  dout_valid_q <= 1'b1;
                  par_err_q    <= par_calc;
                  // A start here chains straight into the next word.
                  state_q      <= start ? CLEAR : IDLE;
               end else begin
                  state_q <= HOLD;
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   // Strobes are decoded from state only, so no input reaches an output
   // through combinational logic.
   assign sr_clear   = (state_q == CLEAR);
   assign sr_shift   = (state_q == SHIFT);
   assign busy       = (state_q != IDLE);
   assign dout       = dout_q;
   assign dout_valid = dout_valid_q;
   assign par_err    = par_err_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_sr_shift_ctrl.sv
module tb_sr_shift_ctrl;
   localparam int W = 4;
`ifdef SR_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   // Age (cycles since the word was accepted) at which capture is due.
   localparam int LAT = W + 2 + (PAR ? 1 : 0);

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         ser_in = 1'b0;
   logic         dout_ready = 1'b0;
   logic [W-1:0] sr_state = '0;
   logic         sr_clear, sr_shift, busy, dout_valid, par_err, overrun;
   logic [W-1:0] dout;

   int checks = 0;
   int failures = 0;
   bit ser_q[$];
   bit sbit;

   always #5 clk = ~clk;

   sr_shift_ctrl #(.WIDTH(W), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort), .ser_in(ser_in),
      .sr_state(sr_state), .sr_clear(sr_clear), .sr_shift(sr_shift), .busy(busy),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .par_err(par_err), .overrun(overrun)
   );

   // Environment: the shift register the controller drives.
   always @(posedge clk) begin
      if (sr_clear) sr_state <= '0;
      else if (sr_shift) begin
         sbit = (ser_q.size() > 0) ? ser_q.pop_front() : bit'($urandom_range(0, 1));
         sr_state <= {sbit, sr_state[W-1:1]};
      end
   end

   // Reference model. It tracks how many cycles a word has been in flight and
   // whether the finished word is still waiting for the output slot.
   int           m_age;
   bit           m_pend, m_vld, m_perr, m_ovr, m_pbit, m_free;
   logic [W-1:0] m_dout;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_age = 0; m_pend = 0; m_vld = 0; m_perr = 0; m_ovr = 0; m_pbit = 0;
         m_dout = '0;
      end else begin
         m_free = !m_vld || dout_ready;
         if (m_vld && dout_ready) m_vld = 0;
         if (m_pend || m_age == LAT) begin
            if (abort) begin
               m_age = 0; m_pend = 0;
            end else if (m_free) begin
               m_dout = sr_state;
               m_vld  = 1;
               m_perr = PAR ? ((^sr_state) ^ m_pbit) : 1'b0;
               m_pend = 0;
               m_age  = start ? 1 : 0;
            end else begin
               m_pend = 1; m_age = 0;
            end
         end else if (m_age == 0) begin
            if (start) m_age = 1;
         end else begin
            if (start) m_ovr = 1;
            if (PAR && m_age == W + 2) m_pbit = ser_in;
            m_age = abort ? 0 : m_age + 1;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (reset) begin
         chk("m_busy", 32'(busy), 32'((m_age != 0) || m_pend));
         chk("m_sr_clear", 32'(sr_clear), 32'(m_age == 1));
         chk("m_sr_shift", 32'(sr_shift), 32'(m_age >= 2 && m_age <= W + 1));
         chk("m_dout_valid", 32'(dout_valid), 32'(m_vld));
         chk("m_dout", 32'(dout), 32'(m_dout));
         chk("m_par_err", 32'(par_err), 32'(m_perr));
         chk("m_overrun", 32'(overrun), 32'(m_ovr));
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push4(input bit b0, input bit b1, input bit b2, input bit b3);
      ser_q.push_back(b0); ser_q.push_back(b1);
      ser_q.push_back(b2); ser_q.push_back(b3);
   endtask

   task automatic drain();
      dout_ready = 1; step(1); dout_ready = 0;
   endtask

   initial begin
      #1 reset = 0;
      step(3);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(dout_valid), 0);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_strobes", 32'({sr_clear, sr_shift}), 0);
      chk("rst_flags", 32'({par_err, overrun}), 0);
      reset = 1;
      step(2);
      chk("idle_busy", 32'(busy), 0);

      // Single word: bits 1,0,1,1 -> 4'b1101.
      push4(1, 0, 1, 1);
      ser_in = 1;
      start = 1; step(1); start = 0;
      step(LAT - 1);
      chk("single_not_yet", 32'(dout_valid), 0);
      step(1);
      chk("single_valid", 32'(dout_valid), 1);
      chk("single_dout", 32'(dout), 32'h0000000D);
      if (PAR) chk("par_ok", 32'(par_err), 0);
      drain();
      chk("drained", 32'(dout_valid), 0);

      // Parity error case: same word with parity bit 0.
      if (PAR) begin
         push4(1, 0, 1, 1);
         ser_in = 0;
         start = 1; step(1); start = 0;
         step(LAT);
         chk("par_err_word", 32'(dout), 32'h0000000D);
         chk("par_err_bad", 32'(par_err), 1);
         drain();
      end

      // Backpressure: words 0110 then 0111 back-to-back with ready low.
      push4(0, 1, 1, 0); push4(1, 1, 1, 0);
      start = 1; step(1); start = 0;
      step(LAT - 1);
      start = 1; step(1); start = 0;
      chk("bp_first", 32'(dout), 32'h6);
      step(LAT);
      chk("bp_hold_busy", 32'(busy), 1);
      chk("bp_hold_noshift", 32'(sr_shift), 0);
      chk("bp_hold_dout", 32'(dout), 32'h6);
      drain();
      chk("bp_second", 32'(dout), 32'h7);
      chk("bp_valid_kept", 32'(dout_valid), 1);
      chk("bp_idle", 32'(busy), 0);
      chk("bp_no_overrun", 32'(overrun), 0);
      drain();

      // Overrun: start pulsed mid-SHIFT, word 0,0,1,1 -> 1100 still completes.
      push4(0, 0, 1, 1);
      start = 1; step(1); start = 0;
      step(2);
      start = 1; step(1); start = 0;
      chk("ovr_set", 32'(overrun), 1);
      step(LAT - 4);
      step(1);
      chk("ovr_word_valid", 32'(dout_valid), 1);
      chk("ovr_word", 32'(dout), 32'hC);
      chk("ovr_sticky", 32'(overrun), 1);
      // Abort in SHIFT with cnt=1, output slot still full.
      start = 1; step(1); start = 0;
      step(2);
      abort = 1; step(1); abort = 0;
      chk("abort_idle", 32'(busy), 0);
      chk("abort_valid_kept", 32'(dout_valid), 1);
      chk("abort_dout_kept", 32'(dout), 32'hC);
      drain();

      // Reset mid-SHIFT (cnt=2).
      start = 1; step(1); start = 0;
      step(3);
      reset = 0; #1;
      chk("midrst_outs", 32'({busy, sr_clear, sr_shift, dout_valid, par_err, overrun}), 0);
      chk("midrst_dout", 32'(dout), 0);
      @(negedge clk); reset = 1;
      step(3);
      chk("midrst_idle", 32'(busy), 0);

      // Random traffic.
      repeat (4000) begin
         start      = ($urandom_range(0, 3) == 0);
         abort      = ($urandom_range(0, 24) == 0);
         dout_ready = ($urandom_range(0, 2) != 0);
         ser_in     = 1'($urandom_range(0, 1));
         step(1);
      end
      start = 0; abort = 0; dout_ready = 0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sr_shift_ctrl.md
Name: sr_shift_ctrl

Overview:
- Controller that sequences the team's serial-in, shift-right shift register (serial bit enters the MSB; the first bit received ends in bit 0).
- Issues clear and shift enables to frame one WIDTH-bit serial word per request.
- Captures the register's parallel state into an output holding register and presents it on a valid/ready handshake.
- Sits between the serial front end and the consumer of parallel words.

Parameters:
- WIDTH, 4: bits per word; must equal the shift register width; legal range 2..15.
- CNT_W, 4: bit counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately.
- start  input  1  request to frame one word; sampled on the clock edge.
- abort  input  1  cancel the word in progress; highest priority after reset.
- ser_in  input  1  serial line; sampled only when SR_PARITY_EN is defined.
- sr_state  input  WIDTH  parallel state of the shift register.
- sr_clear  output  1  one-cycle pulse that zeroes the shift register.
- sr_shift  output  1  shift enable to the shift register.
- busy  output  1  high in every state except IDLE.
- dout  output  WIDTH  captured word; stable while dout_valid=1.
- dout_valid  output  1  captured word available.
- dout_ready  input  1  consumer accepts dout at a clock edge where dout_valid=1 and dout_ready=1.
- par_err  output  1  parity error for the word currently on dout.
- overrun  output  1  sticky: start arrived while a word was being framed.

Behaviour:
- Reset (reset=0): state=IDLE, cnt=0, dout=0, dout_valid=0, par_err=0, overrun=0, sr_clear=0, sr_shift=0.
- All outputs are registered or decoded from state only; no combinational path from any input to any output.
- IDLE:
  - start=1 -> CLEAR.
- CLEAR:
  - sr_clear=1 for this cycle; cnt<=0.
  - Next state: SHIFT.
- SHIFT:
  - sr_shift=1; cnt<=cnt+1 each cycle.
  - When cnt==WIDTH-1: go to CAPTURE, or to PARITY if SR_PARITY_EN is defined.
  - SHIFT therefore lasts exactly WIDTH cycles.
- CAPTURE:
  - sr_shift=0.
  - If dout_valid=0, or dout_ready=1 at this edge: dout<=sr_state, dout_valid<=1. Then go to CLEAR if start=1 (back-to-back framing), otherwise go to IDLE.
  - Otherwise (output slot full): go to HOLD.
- HOLD:
  - Same capture and exit rule as CAPTURE; no shifting.
  - Waits indefinitely for the output slot to free.
- Output handshake:
  - An edge with dout_valid=1 and dout_ready=1 and no new capture clears dout_valid.
  - A capture and an accept at the same edge load the new word with dout_valid staying 1.
- Latency: start sampled at edge E gives dout_valid=1 after edge E+WIDTH+2 (E+WIDTH+3 with parity), provided the output slot is free.
- overrun:
  - Set when start=1 in CLEAR, SHIFT or PARITY.
  - Sticky until reset.
  - Does not disturb the current word.
- abort=1 in CLEAR, SHIFT, PARITY or HOLD:
  - Next state IDLE; cnt<=0; no capture.
  - dout and dout_valid are unchanged.
  - The shift register keeps partial data; the next CLEAR wipes it.
- abort=1 in IDLE or CAPTURE:
  - No state effect in IDLE.
  - In CAPTURE, abort wins: no capture, go to IDLE.
- Reset asserted mid-word: immediate return to the reset state; any partial word is lost.

Optional Feature:
- Macro: SR_PARITY_EN.
- Defined:
  - Adds a PARITY state after SHIFT, lasting one cycle, with sr_shift=0.
  - ser_in is sampled as an even-parity bit.
  - par_err is computed as (^sr_state) ^ ser_in, registered into par_err together with dout at capture.
  - Latency grows by 1.
- Undefined: no PARITY state; par_err is constant 0; ser_in is ignored.

Test Plan:
- Reset: reset=0 mid-SHIFT (cnt=2) -> all outputs 0 and state IDLE immediately; after release, idle until start.
- Single word: WIDTH=4, start 1 cycle, serial 1,0,1,1 fed to the shift register model -> sr_clear 1 cycle, sr_shift 4 cycles, dout=4'b1101 with dout_valid after edge E+6.
- Backpressure: dout_ready=0, two words requested back-to-back (start high at CAPTURE) -> second word waits in HOLD with sr_shift=0 and dout=first word; raising dout_ready for 1 cycle -> dout becomes the second word, dout_valid stays 1.
- Overrun and abort: start pulsed during SHIFT -> overrun=1 sticky, word completes normally; abort during SHIFT cnt=1 -> IDLE next cycle, dout_valid unchanged.
- Parity (SR_PARITY_EN): word 4'b1101 with parity bit 1 -> par_err=0; same word with parity bit 0 -> par_err=1; dout_valid after edge E+7.
